// File: rtl/sio_dmu_pkt_mon.sv
// SIU->DMU outbound packet monitor: decodes headers, tracks payload beats, counts packets and flags protocol errors.
// Optional per-lane parity checker on payload beats is compiled in with SIO_DMU_MON_PARITY_CHK_EN.
module sio_dmu_pkt_mon #(
    parameter int DATA_W  = 128,
    parameter int PAR_W   = DATA_W / 16,
    parameter int BEATS   = 4,
    parameter int TYPE_HI = 127,
    parameter int TAG_LO  = 64,
    parameter int CNT_W   = 16,
    localparam int BIDX_W = $clog2(BEATS) + 1
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              mon_en,
    input  logic              err_clr,
    input  logic              sio_dmu_hdr_vld,
    input  logic              sio_dmu_datareq,
    input  logic [DATA_W-1:0] sio_dmu_data,
    input  logic [PAR_W-1:0]  sio_dmu_parity,
    output logic              pkt_done,
    output logic              pkt_has_data,
    output logic [5:0]        pkt_type,
    output logic [15:0]       pkt_tag,
    output logic              beat_vld,
    output logic [BIDX_W-1:0] beat_idx,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err_overlap,
    output logic              err_orphan,
    output logic              parity_err,
    output logic [CNT_W-1:0]  parity_err_cnt
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t             state_q;
    logic [BIDX_W-1:0]  beat_cnt_q;
    logic               pkt_done_q;
    logic               has_data_q;
    logic [5:0]         type_q;
    logic [15:0]        tag_q;
    logic [CNT_W-1:0]   pkt_cnt_q;
    logic               err_overlap_q;
    logic               err_orphan_q;

    logic in_idle;
    logic in_payload;
    logic last_beat;
    logic hdr_acc;
    logic done_d;
    logic overlap_d;
    logic orphan_d;

    // All event decodes are qualified by mon_en so a disabled monitor is fully quiet.
    assign in_idle    = mon_en && (state_q == ST_IDLE);
    assign in_payload = mon_en && (state_q == ST_PAYLOAD);
    assign last_beat  = (beat_cnt_q == BIDX_W'(BEATS - 1));
    assign hdr_acc    = in_idle && sio_dmu_hdr_vld;
    assign done_d     = (hdr_acc && !sio_dmu_datareq) || (in_payload && last_beat);
    assign overlap_d  = in_payload && sio_dmu_hdr_vld;
    assign orphan_d   = in_idle && !sio_dmu_hdr_vld && sio_dmu_datareq;

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            pkt_done_q    <= 1'b0;
            has_data_q    <= 1'b0;
            type_q        <= '0;
            tag_q         <= '0;
            pkt_cnt_q     <= '0;
            err_overlap_q <= 1'b0;
            err_orphan_q  <= 1'b0;
        end else begin
            pkt_done_q <= done_d;

            if (!mon_en) begin
                state_q    <= ST_IDLE;
                beat_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sio_dmu_hdr_vld) begin
                            type_q     <= sio_dmu_data[TYPE_HI -: 6];
                            tag_q      <= sio_dmu_data[TAG_LO +: 16];
                            has_data_q <= sio_dmu_datareq;
                            beat_cnt_q <= '0;
                            if (sio_dmu_datareq) begin
                                state_q <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        // A header arriving here is an overlap error; the beat still counts.
                        if (last_beat) begin
                            state_q    <= ST_IDLE;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BIDX_W'(1);
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        beat_cnt_q <= '0;
                    end
                endcase
            end

            // Clear has priority over any same-cycle set or increment.
            if (err_clr) begin
                err_overlap_q <= 1'b0;
                err_orphan_q  <= 1'b0;
                pkt_cnt_q     <= '0;
            end else begin
                if (overlap_d) begin
                    err_overlap_q <= 1'b1;
                end
                if (orphan_d) begin
                    err_orphan_q <= 1'b1;
                end
                if (done_d && (pkt_cnt_q != {CNT_W{1'b1}})) begin
                    pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign pkt_done     = pkt_done_q;
    assign pkt_has_data = has_data_q;
    assign pkt_type     = type_q;
    assign pkt_tag      = tag_q;
    assign beat_vld     = in_payload;
    assign beat_idx     = in_payload ? beat_cnt_q : '0;
    assign pkt_cnt      = pkt_cnt_q;
    assign err_overlap  = err_overlap_q;
    assign err_orphan   = err_orphan_q;

`ifdef SIO_DMU_MON_PARITY_CHK_EN
    logic [PAR_W-1:0] lane_bad;
    logic             par_fail;
    logic             par_err_q;
    logic [CNT_W-1:0] par_cnt_q;

    for (genvar i = 0; i < PAR_W; i++) begin : g_lane
        assign lane_bad[i] = sio_dmu_parity[i] ^ (^sio_dmu_data[16*i +: 16]);
    end

    // Only payload beats are checked; header cycles are never in_payload.
    assign par_fail = in_payload && (|lane_bad);

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            par_err_q <= 1'b0;
            par_cnt_q <= '0;
        end else begin
            par_err_q <= par_fail;
            if (err_clr) begin
                par_cnt_q <= '0;
            end else if (par_fail && (par_cnt_q != {CNT_W{1'b1}})) begin
                par_cnt_q <= par_cnt_q + CNT_W'(1);
            end
        end
    end

    assign parity_err     = par_err_q;
    assign parity_err_cnt = par_cnt_q;
`else
    logic unused_par_inputs;
    assign unused_par_inputs = (^sio_dmu_parity) ^ (^sio_dmu_data);
    assign parity_err        = 1'b0;
    assign parity_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_sio_dmu_pkt_mon.sv
// Directed bench for sio_dmu_pkt_mon (CNT_W=4 so saturation is reachable); parity expectations follow SIO_DMU_MON_PARITY_CHK_EN.
module tb_sio_dmu_pkt_mon;

`ifdef SIO_DMU_MON_PARITY_CHK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic         iol2clk = 1'b0;
    logic         rst_l;
    logic         mon_en;
    logic         err_clr;
    logic         hdr_vld;
    logic         datareq;
    logic [127:0] data;
    logic [7:0]   par;
    logic         pkt_done;
    logic         pkt_has_data;
    logic [5:0]   pkt_type;
    logic [15:0]  pkt_tag;
    logic         beat_vld;
    logic [2:0]   beat_idx;
    logic [3:0]   pkt_cnt;
    logic         err_overlap;
    logic         err_orphan;
    logic         parity_err;
    logic [3:0]   parity_err_cnt;

    int nvec = 0;
    int nfail = 0;

    sio_dmu_pkt_mon #(.CNT_W(4)) dut (
        .iol2clk(iol2clk), .rst_l(rst_l), .mon_en(mon_en), .err_clr(err_clr),
        .sio_dmu_hdr_vld(hdr_vld), .sio_dmu_datareq(datareq),
        .sio_dmu_data(data), .sio_dmu_parity(par),
        .pkt_done(pkt_done), .pkt_has_data(pkt_has_data), .pkt_type(pkt_type),
        .pkt_tag(pkt_tag), .beat_vld(beat_vld), .beat_idx(beat_idx), .pkt_cnt(pkt_cnt),
        .err_overlap(err_overlap), .err_orphan(err_orphan),
        .parity_err(parity_err), .parity_err_cnt(parity_err_cnt)
    );

    always #5 iol2clk = ~iol2clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iol2clk);
        #1;
    endtask

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic send_hdr(input logic [5:0] t, input logic [15:0] g, input logic dr);
        logic [127:0] d;
        d = '0;
        d[127:122] = t;
        d[79:64]   = g;
        hdr_vld = 1'b1;
        datareq = dr;
        data    = d;
        par     = good_par(d);
    endtask

    task automatic send_beat();
        hdr_vld = 1'b0;
        datareq = 1'b0;
        data    = {$urandom, $urandom, $urandom, $urandom};
        par     = good_par(data);
    endtask

    task automatic idle();
        hdr_vld = 1'b0;
        datareq = 1'b0;
        data    = '0;
        par     = '0;
    endtask

    initial begin
        rst_l = 1'b0; mon_en = 1'b1; err_clr = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_done", pkt_done, 0);
        chk("rst_cnt", pkt_cnt, 0);
        chk("rst_type", pkt_type, 0);
        chk("rst_tag", pkt_tag, 0);
        chk("rst_hasdata", pkt_has_data, 0);
        chk("rst_beat_vld", beat_vld, 0);
        chk("rst_overlap", err_overlap, 0);
        chk("rst_orphan", err_orphan, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_pcnt", parity_err_cnt, 0);
        rst_l = 1'b1;
        tick();

        // 1: header without payload
        send_hdr(6'h2A, 16'hBEEF, 1'b0);
        tick();
        chk("t1_type", pkt_type, 6'h2A);
        chk("t1_tag", pkt_tag, 16'hBEEF);
        chk("t1_hasdata", pkt_has_data, 0);
        chk("t1_done", pkt_done, 1);
        chk("t1_cnt", pkt_cnt, 1);
        chk("t1_beat_vld", beat_vld, 0);
        idle();
        tick();
        chk("t1_done_clr", pkt_done, 0);

        // 2: header with 4 payload beats
        send_hdr(6'h15, 16'h1234, 1'b1);
        tick();
        chk("t2_type", pkt_type, 6'h15);
        chk("t2_hasdata", pkt_has_data, 1);
        chk("t2_done_hdr", pkt_done, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat();
            chk("t2_beat_vld", beat_vld, 1);
            chk("t2_beat_idx", beat_idx, i);
            tick();
            if (i < 3) chk("t2_done_mid", pkt_done, 0);
        end
        chk("t2_done", pkt_done, 1);
        chk("t2_beat_vld_end", beat_vld, 0);
        chk("t2_cnt", pkt_cnt, 2);
        idle();
        tick();
        chk("t2_done_clr", pkt_done, 0);
        chk("t2_beat_vld_after", beat_vld, 0);

        // 3: header overlapping beat 2
        send_hdr(6'h07, 16'h5555, 1'b1);
        tick();
        send_beat(); tick();
        send_beat(); tick();
        send_hdr(6'h3F, 16'hAAAA, 1'b0);
        chk("t3_idx2", beat_idx, 2);
        tick();
        chk("t3_overlap", err_overlap, 1);
        chk("t3_tag", pkt_tag, 16'h5555);
        chk("t3_type", pkt_type, 6'h07);
        chk("t3_idx3", beat_idx, 3);
        send_beat();
        tick();
        chk("t3_done", pkt_done, 1);
        chk("t3_cnt", pkt_cnt, 3);
        idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_clr_overlap", err_overlap, 0);
        chk("t3_clr_cnt", pkt_cnt, 0);
        chk("t3_clr_type", pkt_type, 6'h07);

        // 4: orphan datareq
        datareq = 1'b1;
        tick();
        chk("t4_orphan", err_orphan, 1);
        chk("t4_beat_vld", beat_vld, 0);
        chk("t4_done", pkt_done, 0);
        chk("t4_cnt", pkt_cnt, 0);
        idle();
        tick();
        chk("t4_still_idle", beat_vld, 0);

        // 5: parity (header carries bad parity, must not be checked)
        send_hdr(6'h09, 16'h0909, 1'b1);
        par = ~par;
        tick();
        chk("t5_hdr_perr", parity_err, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat();
            if (i == 1) par[0] = ~par[0];
            tick();
            chk("t5_perr", parity_err, (i == 1) ? PCHK : 1'b0);
        end
        chk("t5_pcnt", parity_err_cnt, {3'b000, PCHK});
        chk("t5_done", pkt_done, 1);
        chk("t5_cnt", pkt_cnt, 1);
        idle();
        tick();

        // 6a: reset during beat 2
        send_hdr(6'h33, 16'h3333, 1'b1);
        tick();
        send_beat(); tick();
        send_beat(); tick();
        rst_l = 1'b0;
        #1;
        chk("t6a_rst_beat_vld", beat_vld, 0);
        chk("t6a_rst_cnt", pkt_cnt, 0);
        chk("t6a_rst_orphan", err_orphan, 0);
        rst_l = 1'b1;
        idle();
        tick();
        chk("t6a_done", pkt_done, 0);
        chk("t6a_beat_vld", beat_vld, 0);
        send_hdr(6'h11, 16'hCAFE, 1'b0);
        tick();
        chk("t6a_type", pkt_type, 6'h11);
        chk("t6a_tag", pkt_tag, 16'hCAFE);
        chk("t6a_done2", pkt_done, 1);
        chk("t6a_cnt", pkt_cnt, 1);

        // 6b: mon_en dropped mid-payload
        send_hdr(6'h0C, 16'h0C0C, 1'b1);
        tick();
        send_beat(); tick();
        mon_en = 1'b0;
        #1;
        chk("t6b_beat_vld_off", beat_vld, 0);
        tick();
        chk("t6b_done", pkt_done, 0);
        send_hdr(6'h22, 16'h2222, 1'b0);
        tick();
        chk("t6b_type_hold", pkt_type, 6'h0C);
        chk("t6b_done_off", pkt_done, 0);
        chk("t6b_cnt_hold", pkt_cnt, 1);
        mon_en = 1'b1;
        idle();
        tick();
        chk("t6b_idle", beat_vld, 0);
        send_hdr(6'h01, 16'h0001, 1'b0);
        tick();
        chk("t6b_type", pkt_type, 6'h01);
        chk("t6b_done2", pkt_done, 1);
        chk("t6b_cnt", pkt_cnt, 2);

        // 6c: 20 back-to-back packets saturate the 4-bit counter
        for (int k = 1; k <= 20; k++) begin
            send_hdr(6'(k), 16'(k), 1'b0);
            tick();
            chk("t6c_done", pkt_done, 1);
            chk("t6c_cnt", pkt_cnt, (k + 2 > 15) ? 15 : k + 2);
        end
        chk("t6c_sat", pkt_cnt, 15);

        // clear beats a same-cycle increment
        send_hdr(6'h03, 16'h0003, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_done", pkt_done, 1);
        chk("clr_cnt", pkt_cnt, 0);
        idle();
        tick();
        chk("clr_done_end", pkt_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
